// File: rtl/seq_alu_unit.sv
// seq_alu_unit: sequential handshaked ALU (add, and, shift-add multiply, increment), one op in flight.
// Latency: 1 cycle accept->Out_Valid for add/and/inc, Width+1 cycles for multiply.
// Backpressure: In_Ready low while busy; Out/Out_Valid held until Out_Ready, In_Ready returns the cycle after retirement.
//
// Ports:
//   CLK, RST            clock, synchronous active-low reset
//   A, B, Sel           operands and opcode (00 add, 01 and, 10 mul, 11 inc A), latched on accept
//   In_Valid/In_Ready   request handshake
//   Out/Out_Valid       2*Width result, zero-extended, with valid
//   Out_Ready           result consumer ready
//   Zero, Carry         result flags, present only when SEQ_ALU_FLAGS_EN is defined
module seq_alu_unit #(
  parameter int Width = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [Width-1:0]   A,
  input  logic [Width-1:0]   B,
  input  logic [1:0]         Sel,
  input  logic               In_Valid,
  output logic               In_Ready,
  output logic [2*Width-1:0] Out,
  output logic               Out_Valid,
  input  logic               Out_Ready
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic               Zero,
  output logic               Carry
`endif
);

  localparam int CW = $clog2(Width + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [Width-1:0]   r_a, w_a_nxt;
  logic [Width-1:0]   r_b, w_b_nxt;
  logic [2*Width-1:0] r_acc, w_acc_nxt;
  logic [2*Width-1:0] r_out, w_out_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;

  logic               w_accept;
  logic               w_mul_last;
  logic [Width:0]     w_sum;
  logic [Width:0]     w_inc;
  logic [2*Width-1:0] w_op_res;
  logic [2*Width-1:0] w_pp;
  logic [2*Width-1:0] w_acc_add;

  assign w_accept   = In_Valid && (r_state == S_IDLE);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(Width - 1));

  assign w_sum = {1'b0, A} + {1'b0, B};
  assign w_inc = {1'b0, A} + {{Width{1'b0}}, 1'b1};

  // Partial product for this iteration: A weighted by the bit position being consumed.
  // r_b is shifted right each cycle, so its LSB is always the bit at position r_cnt.
  assign w_pp      = {{Width{1'b0}}, r_a} << r_cnt;
  assign w_acc_add = r_acc + (r_b[0] ? w_pp : '0);

  always_comb begin
    w_op_res = '0;
    case (Sel)
      2'b00:   w_op_res = {{(Width-1){1'b0}}, w_sum};
      2'b01:   w_op_res = {{Width{1'b0}}, A & B};
      2'b11:   w_op_res = {{(Width-1){1'b0}}, w_inc};
      default: w_op_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    In_Ready    = 1'b0;
    Out_Valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        In_Ready = 1'b1;
        if (w_accept) begin
          w_a_nxt = A;
          w_b_nxt = B;
          if (Sel == 2'b10) begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_MUL;
          end else begin
            w_out_nxt   = w_op_res;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt = w_acc_add;
        w_b_nxt   = r_b >> 1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_mul_last) begin
          w_out_nxt   = w_acc_add;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign Out = r_out;

`ifdef SEQ_ALU_FLAGS_EN
  logic r_zero;
  logic r_carry;
  logic w_op_carry;

  // Only add and inc can carry out of the low Width bits.
  assign w_op_carry = (Sel == 2'b00) ? w_sum[Width] :
                      (Sel == 2'b11) ? w_inc[Width] : 1'b0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_accept && (Sel != 2'b10)) begin
      r_zero  <= (w_op_res == '0);
      r_carry <= w_op_carry;
    end else if (w_mul_last) begin
      r_zero  <= (w_acc_add == '0);
      r_carry <= 1'b0;
    end
  end

  assign Zero  = r_zero;
  assign Carry = r_carry;
`endif

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: self-checking bench for seq_alu_unit against an arithmetic reference model.
// Latency: n/a (bench).
// Backpressure: drives randomized Out_Ready hold-off and busy-time request spam.
module tb_seq_alu_unit;

  localparam int W = 8;

  logic           CLK;
  logic           RST;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     Sel;
  logic           In_Valid;
  logic           In_Ready;
  logic [2*W-1:0] Out;
  logic           Out_Valid;
  logic           Out_Ready;
`ifdef SEQ_ALU_FLAGS_EN
  logic           Zero;
  logic           Carry;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu_unit #(.Width(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready)
`ifdef SEQ_ALU_FLAGS_EN
    ,
    .Zero      (Zero),
    .Carry     (Carry)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: the arithmetic meaning of each opcode, at full precision.
  function automatic int unsigned ref_result(input int unsigned a, input int unsigned b,
                                             input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a * b;
      default: return a + 1;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] s);
    return (s == 2'b10) ? W + 1 : 1;
  endfunction

  // Issue one request, wait for its result, optionally hold it off, retire it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                       input int hold, input bit spam);
    int unsigned exp_v;
    int lat;
    bit busy_ok;
    bit hold_ok;
    exp_v = ref_result(a, b, s);
    @(negedge CLK);
    A = a; B = b; Sel = s; In_Valid = 1'b1;
    Out_Ready = (hold == 0);
    chk("in_ready_idle", {31'b0, In_Ready}, 1);
    @(posedge CLK);
    @(negedge CLK);
    In_Valid = spam;
    lat = 1;
    busy_ok = 1'b1;
    while (!Out_Valid && lat < 200) begin
      if (In_Ready) busy_ok = 1'b0;
      if (spam) begin
        A = W'($urandom); B = W'($urandom); Sel = 2'($urandom);
      end
      @(negedge CLK);
      lat++;
    end
    In_Valid = 1'b0;
    chk("latency", lat, ref_latency(s));
    chk("busy_in_ready_low", {31'b0, busy_ok}, 1);
    chk("in_ready_done", {31'b0, In_Ready}, 0);
    chk("result", {16'b0, Out}, exp_v);
`ifdef SEQ_ALU_FLAGS_EN
    chk("zero_flag", {31'b0, Zero}, (exp_v == 0) ? 1 : 0);
    chk("carry_flag", {31'b0, Carry}, ((s == 2'b00 || s == 2'b11) && exp_v[W]) ? 1 : 0);
`endif
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        if (!Out_Valid || Out !== exp_v[2*W-1:0] || In_Ready) hold_ok = 1'b0;
      end
      chk("hold_stable", {31'b0, hold_ok}, 1);
      Out_Ready = 1'b1;
    end
    @(negedge CLK);
    chk("retire_valid_low", {31'b0, Out_Valid}, 0);
    chk("retire_in_ready", {31'b0, In_Ready}, 1);
    chk("retire_out_kept", {16'b0, Out}, exp_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet_ok;
    RST = 1'b0; A = '0; B = '0; Sel = '0; In_Valid = 1'b0; Out_Ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_out", {16'b0, Out}, 0);
    chk("reset_out_valid", {31'b0, Out_Valid}, 0);
    chk("reset_in_ready", {31'b0, In_Ready}, 1);
`ifdef SEQ_ALU_FLAGS_EN
    chk("reset_zero", {31'b0, Zero}, 0);
    chk("reset_carry", {31'b0, Carry}, 0);
`endif
    RST = 1'b1;
    @(negedge CLK);

    // Directed cases
    do_op(8'd20, 8'd0, 2'b00, 0, 1'b0);
    do_op(8'd255, 8'd255, 2'b10, 0, 1'b1);
    do_op(8'd255, 8'd0, 2'b11, 0, 1'b0);
    do_op(8'h0F, 8'hF0, 2'b01, 0, 1'b0);
    do_op(8'd7, 8'd6, 2'b10, 5, 1'b0);
    do_op(8'd0, 8'd99, 2'b10, 0, 1'b0);
    do_op(8'd255, 8'd255, 2'b00, 2, 1'b0);

    // Reset during a multiply discards the operation
    @(negedge CLK);
    A = 8'd200; B = 8'd3; Sel = 2'b10; In_Valid = 1'b1; Out_Ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    In_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midreset_out", {16'b0, Out}, 0);
    chk("midreset_out_valid", {31'b0, Out_Valid}, 0);
    chk("midreset_in_ready", {31'b0, In_Ready}, 1);
    RST = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge CLK);
      if (Out_Valid) quiet_ok = 1'b0;
    end
    chk("midreset_no_result", {31'b0, quiet_ok}, 1);
    do_op(8'd3, 8'd4, 2'b00, 0, 1'b0);

    // Sweep
    for (int i = 0; i <= 20; i++) begin
      for (int s = 0; s < 4; s++) begin
        do_op(W'(i), W'(20 - i), 2'(s), 0, 1'b0);
      end
    end

    // Random traffic with random hold-off and busy-time spam
    for (int k = 0; k < 40; k++) begin
      do_op(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
